// File: rtl/datapath.sv
// Datapath half of an iterative unsigned factorial engine.
// Holds loop counter i, running product fi and the result register. It also
// provides the incrementer, the multiplier and the i < X comparator that the
// external controller uses as its loop condition.
module datapath #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] X,
  input  logic         ld_i,
  input  logic         ld_fi,
  input  logic         ld_o,
  input  logic         st,
  output logic         i_lt_x,
  output logic [W-1:0] fi_out
);

  logic [W-1:0]   i_reg, i_next;
  logic [W-1:0]   fi_reg, fi_next;
  logic [W-1:0]   out_reg, out_next;
  logic [2*W-1:0] prod;

  // Full-width product of the pre-edge fi and i; only the low W bits are kept
  // (overflow is silent truncation).
  assign prod = {{W{1'b0}}, fi_reg} * {{W{1'b0}}, i_reg};

  // Next-state selection: every register sees pre-edge values, so the
  // enables are fully independent of one another.
  always_comb begin
    i_next   = i_reg;
    fi_next  = fi_reg;
    out_next = out_reg;
    if (ld_i) begin
      i_next = st ? W'(1) : i_reg + W'(1);
    end
    if (ld_fi) begin
      fi_next = st ? W'(1) : prod[W-1:0];
    end
    if (ld_o) begin
      out_next = fi_reg;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      i_reg   <= '0;
      fi_reg  <= '0;
      out_reg <= '0;
    end else begin
      i_reg   <= i_next;
      fi_reg  <= fi_next;
      out_reg <= out_next;
    end
  end

  assign i_lt_x = (i_reg < X);
  assign fi_out = out_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the factorial datapath.
// Internal i and fi are observed through the ports only: i via the i_lt_x
// flag probed with chosen X values, fi by copying it out with ld_o.
module tb_datapath;

  logic       CLK;
  logic       RST;
  logic [7:0] X;
  logic       ld_i;
  logic       ld_fi;
  logic       ld_o;
  logic       st;
  logic       i_lt_x;
  logic [7:0] fi_out;

  int checks;
  int failures;

  datapath #(.W(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .X      (X),
    .ld_i   (ld_i),
    .ld_fi  (ld_fi),
    .ld_o   (ld_o),
    .st     (st),
    .i_lt_x (i_lt_x),
    .fi_out (fi_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  // Apply one cycle of strobes, clock it, then drop the strobes 1 time unit
  // after the edge so outputs can be sampled away from the edge.
  task automatic step(input logic li, input logic lf, input logic lo, input logic s);
    ld_i  = li;
    ld_fi = lf;
    ld_o  = lo;
    st    = s;
    @(posedge CLK);
    #1;
    ld_i  = 1'b0;
    ld_fi = 1'b0;
    ld_o  = 1'b0;
  endtask

  // Probe the flag with a chosen X (no clock edge crossed).
  task automatic probe(input string tag, input logic [7:0] xv, input logic exp_v);
    X = xv;
    #1;
    chk(tag, {7'd0, i_lt_x}, {7'd0, exp_v});
  endtask

  int iters;

  initial begin
    checks   = 0;
    failures = 0;
    ld_i = 0; ld_fi = 0; ld_o = 0; st = 0;
    X   = 8'd3;
    RST = 1'b0;

    // Reset state
    #3;
    chk("rst_fi_out", fi_out, 8'd0);
    chk("rst_i_lt_x_x3", {7'd0, i_lt_x}, 8'd1);
    probe("rst_i_lt_x_x0", 8'd0, 1'b0);
    X = 8'd3;

    // Release, idle three cycles: nothing may change
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) step(0, 0, 0, 0);
    chk("idle_fi_out", fi_out, 8'd0);
    probe("idle_i_is_0", 8'd1, 1'b1);

    // Init sequence, st=1, separate strobes
    step(1, 0, 0, 1);
    probe("init_i1_x1", 8'd1, 1'b0);
    probe("init_i1_x3", 8'd3, 1'b1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    chk("init_fi_out", fi_out, 8'd1);

    // Loop X=3, pass 1
    step(1, 0, 0, 0);
    probe("p1_i2_x2", 8'd2, 1'b0);
    probe("p1_i2_x3", 8'd3, 1'b1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("p1_fi", fi_out, 8'd2);
    // pass 2
    step(1, 0, 0, 0);
    probe("p2_i3_x3", 8'd3, 1'b0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("p2_fi_3fact", fi_out, 8'd6);
    // pass 3, result register must hold until ld_o
    step(1, 0, 0, 0);
    probe("p3_i4_x4", 8'd4, 1'b0);
    probe("p3_i4_x5", 8'd5, 1'b1);
    step(0, 1, 0, 0);
    chk("p3_out_held", fi_out, 8'd6);
    step(0, 0, 1, 0);
    chk("p3_fi_24", fi_out, 8'd24);

    // Same-cycle loads: init both together, then i=2, fi=2
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);            // i=3, fi=2*2=4
    probe("same_i3_x3", 8'd3, 1'b0);
    probe("same_i3_x4", 8'd4, 1'b1);
    step(0, 1, 1, 0);            // fi=4*3=12, out gets old fi=4
    chk("same_out_old_fi", fi_out, 8'd4);
    step(0, 0, 1, 0);
    chk("same_fi_12", fi_out, 8'd12);

    // Overflow: X=6 full loop driven by the flag, bounded
    X = 8'd6;
    step(1, 1, 0, 1);
    iters = 0;
    while (i_lt_x === 1'b1 && iters < 20) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      iters++;
    end
    chk("ovf_iters", 8'(iters), 8'd5);
    step(0, 0, 1, 0);
    chk("ovf_fi_208", fi_out, 8'd208);

    // X=1: loop exits immediately, result 1
    X = 8'd1;
    step(1, 1, 0, 1);
    chk("x1_i_lt_x", {7'd0, i_lt_x}, 8'd0);
    step(0, 0, 1, 0);
    chk("x1_fi_out", fi_out, 8'd1);

    // Counter wrap: i=1, then 253 increments -> 254, then 255, then 0
    step(1, 0, 0, 1);
    repeat (253) step(1, 0, 0, 0);
    probe("wrap_i254_x255", 8'd255, 1'b1);
    step(1, 0, 0, 0);
    probe("wrap_i255_x255", 8'd255, 1'b0);
    step(1, 0, 0, 0);
    probe("wrap_i0_x1", 8'd1, 1'b1);

    // Async reset mid-loop, between edges
    X = 8'd3;
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("mid_fi_out", fi_out, 8'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("async_fi_out", fi_out, 8'd0);
    probe("async_i0_x1", 8'd1, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) step(0, 0, 0, 0);
    probe("post_rst_i0", 8'd1, 1'b1);
    step(0, 0, 1, 0);
    chk("post_rst_fi0", fi_out, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Register/arithmetic half of an iterative unsigned factorial engine; a separate controller FSM drives the load/select strobes and watches the loop-condition flag.
- Computes fi = X! with the loop: i=1, fi=1; while (i < X) { i=i+1; fi=fi*i; }; out=fi.
- Holds three registers (loop counter i, running product fi, result register), one incrementer, one multiplier and one comparator.

Parameters:
- W, 8, data width of X, i, fi and the result register.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset (0 = reset asserted).
- X  input  W  unsigned operand n whose factorial is computed.
- ld_i  input  1  load enable for counter register i.
- ld_fi  input  1  load enable for product register fi.
- ld_o  input  1  load enable for result register (copies fi).
- st  input  1  init select: 1 = load initial constants, 0 = load loop-update values.
- i_lt_x  output  1  combinational flag, 1 when i < X (unsigned).
- fi_out  output  W  result register contents.

Behaviour:
- Reset: RST=0 immediately, independent of CLK, clears i, fi and the result register to 0. Outputs during reset: fi_out=0, i_lt_x=(0<X), i.e. 1 for any X>0.
- All register updates happen on the rising CLK edge while RST=1. Each register holds its value when its load enable is 0.
- i register:
  - ld_i=1, st=1: i <= 1.
  - ld_i=1, st=0: i <= i+1, modulo 2^W (255 wraps to 0).
- fi register:
  - ld_fi=1, st=1: fi <= 1.
  - ld_fi=1, st=0: fi <= low W bits of (fi * i), using the current (pre-edge) value of i.
- Result register: ld_o=1 -> fi_out <= current fi; st has no effect on it.
- Simultaneous loads: enables are independent; any combination may be active in one cycle.
  - Every register samples pre-edge values.
  - ld_i & ld_fi with st=0: fi uses the old i. The controller must sequence i before fi to get a correct factorial.
  - ld_fi & ld_o together: fi_out receives the old fi.
- i_lt_x: purely combinational from the current i and X, no latency. It updates in the same cycle i or X changes.
- No internal state machine; latency of every load is one clock.
- Overflow: the product is truncated to W bits with no flag. Results are exact for X <= 5 at W=8; 6! = 720 is stored as 208.
- X=0 or X=1: after init i=1, so i_lt_x=0 and fi_out=1 once ld_o is issued.
- Reset asserted mid-computation clears all three registers at once. After release, nothing changes until the next load strobe.

Test Plan:
- Reset: hold RST=0 with X=3 -> fi_out=0, i_lt_x=1. Release RST with all enables low for 3 cycles -> registers stay 0.
- Init: st=1, pulse ld_i, then pulse ld_fi, then ld_o one cycle each -> i=1, fi=1, fi_out=1, i_lt_x=1 (X=3).
- Loop, X=3, st=0, alternating ld_i then ld_fi:
  - Pass 1 -> i=2, fi=2, i_lt_x=1.
  - Pass 2 -> i=3, fi=6, i_lt_x=0.
  - Pulse ld_o -> fi_out=6.
  - Continue a 3rd pass -> i=4, fi=24, fi_out still 6 until ld_o.
- Same-cycle ld_i & ld_fi with st=0 from i=2, fi=2 -> i=3, fi=4 (old i used). Same-cycle ld_fi & ld_o -> fi_out gets pre-edge fi.
- Overflow, X=6 full loop -> fi=208 (720 mod 256). Wrap: i=255 plus ld_i (st=0) -> i=0.
- Async reset: assert RST=0 between clock edges mid-loop -> i, fi, fi_out go to 0 immediately.
